// File: rtl/mac_razor_pkg.sv
// Shared types and helpers for the timing-speculative MAC processing element.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mac_razor_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_ERR_CNT_W = 16;

  // Widest accumulator the product-sum helper can evaluate exactly.
  localparam int MAX_ACC_W = 64;

  typedef enum logic {
    MODE_PASS = 1'b0,  // addend comes from the upstream PE
    MODE_ACC  = 1'b1   // addend is the local accumulator
  } acc_mode_e;

  // addend + a*b on zero-extended operands; callers truncate to ACC_W,
  // which yields the wrap-around sum mod 2^ACC_W.
  function automatic logic [MAX_ACC_W-1:0] prod_sum(
    input logic [MAX_ACC_W-1:0] addend,
    input logic [MAX_ACC_W-1:0] a,
    input logic [MAX_ACC_W-1:0] b
  );
    return addend + a * b;
  endfunction

endpackage

// File: rtl/mac_razor_shadow_chk.sv
// Shadow checker: holds the operands of the last accepted beat and recomputes its result.
// Latency: mismatch/shadow valid in the cycle after the capture edge (combinational from op regs).
// Backpressure: none itself; the top stalls input on mismatch.
module mac_razor_shadow_chk
  import mac_razor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [DATA_W-1:0] activ,
  input  logic [DATA_W-1:0] weight,
  input  logic [ACC_W-1:0]  addend,
  input  logic              mode,
  input  logic [ACC_W-1:0]  main_q,
  output logic              mismatch,
  output logic [ACC_W-1:0]  shadow,
  output logic              chk_mode
);

  logic [DATA_W-1:0] op_activ;
  logic [DATA_W-1:0] op_weight;
  logic [ACC_W-1:0]  op_addend;
  logic              op_mode;
  logic              chk_pend;

  // Capture true operands at every accept; a check is pending only for the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_activ  <= '0;
      op_weight <= '0;
      op_addend <= '0;
      op_mode   <= 1'b0;
      chk_pend  <= 1'b0;
    end else begin
      chk_pend <= cap;
      if (cap) begin
        op_activ  <= activ;
        op_weight <= weight;
        op_addend <= addend;
        op_mode   <= mode;
      end
    end
  end

  assign shadow   = ACC_W'(prod_sum(MAX_ACC_W'(op_addend), MAX_ACC_W'(op_activ),
                                    MAX_ACC_W'(op_weight)));
  assign mismatch = chk_pend && (shadow != main_q);
  assign chk_mode = op_mode;

endmodule

// File: rtl/mac_pe_razor.sv
// Timing-speculative MAC PE: psum_out = addend + activ*weight, shadow-checked and replayed on error.
// Latency: 1 cycle to psum_out; a corrected re-issue follows one cycle later on mismatch.
// Backpressure: in_ready drops for the check cycle of a mismatching beat (one-cycle bubble).
// Optional build macro: RAZOR_ERR_INJECT_EN adds inj_en/inj_mask to corrupt the main path.
module mac_pe_razor
  import mac_razor_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    activ_in,
  input  logic [DATA_W-1:0]    weight_in,
  input  logic [ACC_W-1:0]     psum_in,
  input  logic                 acc_mode,
  input  logic                 acc_clr,
  output logic [DATA_W-1:0]    activ_out,
  output logic [ACC_W-1:0]     psum_out,
  output logic                 out_valid,
  output logic                 out_replay,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef RAZOR_ERR_INJECT_EN
  ,
  input  logic                 inj_en,
  input  logic [ACC_W-1:0]     inj_mask
`endif
);

  generate
    if (ACC_W < 2 * DATA_W || ACC_W > MAX_ACC_W) begin : g_bad_acc_w
      $error("mac_pe_razor: ACC_W must lie in [2*DATA_W, MAX_ACC_W]");
    end
  endgenerate

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] err_mask;
  logic [ACC_W-1:0] main_sum;
  logic [ACC_W-1:0] shadow;
  logic             mismatch;
  logic             chk_mode;
  logic             accept;
  logic             mode_acc;

`ifdef RAZOR_ERR_INJECT_EN
  assign err_mask = inj_en ? inj_mask : '0;
`else
  assign err_mask = '0;
`endif

  assign mode_acc = (acc_mode == MODE_ACC);
  assign in_ready = !rst && !mismatch;
  assign accept   = in_valid && in_ready;

  // A clear on an accumulate beat makes that beat start from zero.
  assign addend   = mode_acc ? (acc_clr ? '0 : acc_q) : psum_in;
  assign sum      = ACC_W'(prod_sum(MAX_ACC_W'(addend), MAX_ACC_W'(activ_in),
                                    MAX_ACC_W'(weight_in)));
  assign main_sum = sum ^ err_mask;

  mac_razor_shadow_chk #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_shadow_chk (
    .clk      (clk),
    .rst      (rst),
    .cap      (accept),
    .activ    (activ_in),
    .weight   (weight_in),
    .addend   (addend),
    .mode     (acc_mode),
    .main_q   (psum_out),
    .mismatch (mismatch),
    .shadow   (shadow),
    .chk_mode (chk_mode)
  );

  // Output register: new result on accept, corrected re-issue on mismatch, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_out   <= '0;
      activ_out  <= '0;
      out_valid  <= 1'b0;
      out_replay <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      out_valid  <= accept || mismatch;
      out_replay <= mismatch;
      err_pulse  <= mismatch;
      if (accept) begin
        psum_out  <= main_sum;
        activ_out <= activ_in;
      end else if (mismatch) begin
        psum_out <= shadow;
      end
    end
  end

  // Local accumulator: clear has priority over correction; accept and mismatch never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (accept && mode_acc) begin
      acc_q <= main_sum;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (mismatch && chk_mode) begin
      acc_q <= shadow;
    end
  end

  // Saturating count of detected mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
